health_manager: RTL and testbench
=================================

# health_manager

Game-state block that owns both players' health and produces the four values the scoreboard draws: base health (HP1, HP2) and padded health (HPP1, HPP2). Padded health is a lagging "recent damage" trail. It holds after a hit, then drains one point at a time toward base health, paced by the video frame. The block sits between the hit-detection/combat logic (damage events) and the scoreboard (bar rendering). It also reports knockouts to the round controller.

## Interface
Parameters:
- MAX_HP, 100: full health; the bar renders 2 px per point, so 100 fills 200 px.
- HOLD_FRAMES, 30: frame ticks padded health holds after the most recent hit.
- DRAIN_FRAMES, 2: frame ticks per 1-point drain step.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  raw vertical-sync-rate strobe; the block synchronises it internally and edge-detects it.
- round_start  in  1  single-cycle pulse that restores both players to full health.
- dmg_valid1, dmg_valid2  in  1  single-cycle damage event for player 1 / player 2.
- dmg_amt1, dmg_amt2  in  8  damage amount; sampled only when the matching valid is high.
- HP1, HP2  out  10  base health; range 0..MAX_HP.
- HPP1, HPP2  out  10  padded health; always HP ≤ HPP ≤ MAX_HP.
- KO1, KO2  out  1  sticky knockout flag.

## Operation
- Two identical, independent channels, one per player. Each channel has an FSM with states HB_IDLE, HB_HOLD and HB_DRAIN, plus a hold/drain frame counter.
- Frame tick: frame_clk passes through a 2-flop synchroniser. tick is high for exactly one Clk when the synchronised value goes 0→1.
- Damage (valid high and KO clear):
  - HP ← HP − amt, saturating at 0; if amt ≥ HP, HP becomes 0.
  - HPP is unchanged.
  - State → HB_HOLD and the counter reloads to HOLD_FRAMES. This applies from any state, so a re-hit restarts the hold.
  - amt = 0 still counts as a hit: state → HB_HOLD and the counter reloads.
- HB_HOLD: the counter decrements on each tick. On the tick that brings it to 0, state → HB_DRAIN and the counter loads DRAIN_FRAMES.
- HB_DRAIN: the counter decrements on each tick. On the tick that brings it to 0, HPP ← HPP − 1 and the counter reloads. When HPP equals HP after a decrement, state → HB_IDLE.
- HB_IDLE: HPP == HP; ticks are ignored.
- KO: set in the cycle HP becomes 0. Once KO is set, damage to that player is ignored and the padded trail continues draining to 0. KO clears only on round_start or Reset.
- round_start: HP = HPP = MAX_HP, state HB_IDLE, counter 0, KO clear, for both players.
- Priority within one cycle: Reset > round_start > damage > tick. When damage and a tick coincide, the damage is applied and the tick is discarded for that channel.
- Damage to the two players in the same cycle: both are applied independently.

## Timing
- Reset values: HP1 = HP2 = HPP1 = HPP2 = MAX_HP, KO1 = KO2 = 0, both FSMs in HB_IDLE, synchroniser flops cleared.
- All outputs are registered.
- Damage latency: HP is updated and KO set at the first Clk edge after the valid cycle.
- frame_clk rise to internal tick: 3 Clk edges. frame_clk must be high for at least 2 Clk to be counted.
- A single hit with HOLD_FRAMES = H, DRAIN_FRAMES = D and damage d: HPP reaches HP after H + d·D ticks (no re-hits).
- Output width rule: the upper bits above log2(MAX_HP) are always 0. The scoreboard doubles the low 9 bits.

## Structure
- Package health_pkg:
  - the MAX_HP default;
  - typedef enum hb_state_t {HB_IDLE, HB_HOLD, HB_DRAIN};
  - the HP width constant (10).
- Sub-module health_channel: one player's HP/HPP registers, FSM, counter and KO flag. It is instantiated twice.
- The top level holds the frame-clock synchroniser/edge detector and wires the tick and round_start to both channels.

## Test plan
All scenarios use HOLD_FRAMES = 30 and DRAIN_FRAMES = 2.
- Reset, then 5 frames with no other stimulus → HP1 = HP2 = HPP1 = HPP2 = 100, KO1 = KO2 = 0 throughout.
- dmg_amt1 = 10 → next cycle HP1 = 90, HPP1 = 100. HPP1 is still 100 after 30 ticks, is 99 after 32 ticks, and is 90 after 50 ticks; the FSM is then HB_IDLE. Player 2 is untouched.
- HP2 = 100, dmg_amt2 = 150 → HP2 = 0 and KO2 = 1 next cycle. A further dmg_amt2 = 5 is ignored. HPP2 drains to 0 after 230 ticks.
- Re-hit during drain: HP1 = 90, HPP1 = 95, dmg_amt1 = 5 → HP1 = 85. HPP1 stays 95 for 30 ticks, then drains to 85.
- round_start in the same cycle as dmg_valid1 (amt 20) with KO2 set → next cycle all HP/HPP = 100, KO2 = 0, damage dropped.
- dmg_valid1 (7), dmg_valid2 (3) and a tick in the same cycle during player 1 drain → HP1 −7, HP2 −3, both channels HB_HOLD, no HPP decrement that cycle.

Source files
------------

// File: rtl/health_pkg.sv
// Shared constants and FSM state type for the player-health block.
package health_pkg;

  localparam int unsigned MAX_HP_DEFAULT = 100;
  localparam int unsigned HP_W           = 10;
  localparam int unsigned DMG_W          = 8;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic [1:0] {
    HB_IDLE,
    HB_HOLD,
    HB_DRAIN
  } hb_state_t;

endpackage

// File: rtl/health_manager_if.sv
// Bundle of frame/round strobes, damage events and scoreboard-facing health outputs.
interface health_manager_if;
  import health_pkg::*;

  logic             frame_clk;
  logic             round_start;
  logic             dmg_valid1;
  logic             dmg_valid2;
  logic [DMG_W-1:0] dmg_amt1;
  logic [DMG_W-1:0] dmg_amt2;
  logic [HP_W-1:0]  HP1;
  logic [HP_W-1:0]  HP2;
  logic [HP_W-1:0]  HPP1;
  logic [HP_W-1:0]  HPP2;
  logic             KO1;
  logic             KO2;

  modport master (
    output frame_clk, round_start, dmg_valid1, dmg_valid2, dmg_amt1, dmg_amt2,
    input  HP1, HP2, HPP1, HPP2, KO1, KO2
  );

  modport slave (
    input  frame_clk, round_start, dmg_valid1, dmg_valid2, dmg_amt1, dmg_amt2,
    output HP1, HP2, HPP1, HPP2, KO1, KO2
  );

endinterface

// File: rtl/health_channel.sv
// One player's base health, lagging padded-health trail, hold/drain FSM and sticky KO.
module health_channel
  import health_pkg::*;
#(
  parameter int unsigned MAX_HP       = MAX_HP_DEFAULT,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned DRAIN_FRAMES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             roundStart,
  input  logic             tick,
  input  logic             dmgValid,
  input  logic [DMG_W-1:0] dmgAmt,
  output logic [HP_W-1:0]  hp,
  output logic [HP_W-1:0]  hpp,
  output logic             ko
);

  localparam logic [HP_W-1:0]  FullHp   = HP_W'(MAX_HP);
  localparam logic [CNT_W-1:0] HoldCnt  = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] DrainCnt = CNT_W'(DRAIN_FRAMES);

  hb_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [HP_W-1:0]  amtExt;
  logic [HP_W-1:0]  hppDec;

  assign amtExt = HP_W'(dmgAmt);
  assign hppDec = hpp - HP_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset || roundStart) begin
      hp    <= FullHp;
      hpp   <= FullHp;
      ko    <= 1'b0;
      state <= HB_IDLE;
      cnt   <= '0;
    end else if (dmgValid && !ko) begin
      // A hit (even of zero) restarts the hold; a coincident tick is dropped.
      if (amtExt >= hp) begin
        hp <= '0;
        ko <= 1'b1;
      end else begin
        hp <= hp - amtExt;
      end
      state <= HB_HOLD;
      cnt   <= HoldCnt;
    end else if (tick) begin
      case (state)
        HB_HOLD: begin
          if (cnt <= CNT_W'(1)) begin
            // Nothing to drain after a zero-damage hit on a settled bar.
            if (hpp == hp) begin
              state <= HB_IDLE;
              cnt   <= '0;
            end else begin
              state <= HB_DRAIN;
              cnt   <= DrainCnt;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HB_DRAIN: begin
          if (cnt <= CNT_W'(1)) begin
            hpp <= hppDec;
            if (hppDec == hp) begin
              state <= HB_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= DrainCnt;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= HB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/health_manager.sv
// Synchronises the frame strobe into a one-cycle tick and drives two health channels.
module health_manager
  import health_pkg::*;
#(
  parameter int unsigned MAX_HP       = MAX_HP_DEFAULT,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned DRAIN_FRAMES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  health_manager_if.slave  bus
);

  logic frameSync1;
  logic frameSync2;
  logic frameSyncPrev;
  logic tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frameSync1    <= 1'b0;
      frameSync2    <= 1'b0;
      frameSyncPrev <= 1'b0;
    end else begin
      frameSync1    <= bus.frame_clk;
      frameSync2    <= frameSync1;
      frameSyncPrev <= frameSync2;
    end
  end

  assign tick = frameSync2 & ~frameSyncPrev;

  health_channel #(
    .MAX_HP      (MAX_HP),
    .HOLD_FRAMES (HOLD_FRAMES),
    .DRAIN_FRAMES(DRAIN_FRAMES)
  ) u_channel1 (
    .Clk       (Clk),
    .Reset     (Reset),
    .roundStart(bus.round_start),
    .tick      (tick),
    .dmgValid  (bus.dmg_valid1),
    .dmgAmt    (bus.dmg_amt1),
    .hp        (bus.HP1),
    .hpp       (bus.HPP1),
    .ko        (bus.KO1)
  );

  health_channel #(
    .MAX_HP      (MAX_HP),
    .HOLD_FRAMES (HOLD_FRAMES),
    .DRAIN_FRAMES(DRAIN_FRAMES)
  ) u_channel2 (
    .Clk       (Clk),
    .Reset     (Reset),
    .roundStart(bus.round_start),
    .tick      (tick),
    .dmgValid  (bus.dmg_valid2),
    .dmgAmt    (bus.dmg_amt2),
    .hp        (bus.HP2),
    .hpp       (bus.HPP2),
    .ko        (bus.KO2)
  );

endmodule

// File: tb/tb_health_manager.sv
// Self-checking bench for health_manager: directed scenarios plus randomized hits and frames.
module tb_health_manager;
  import health_pkg::*;

  localparam int MaxHp = 100;
  localparam int Hold  = 30;
  localparam int Drain = 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  health_manager_if hif();

  health_manager #(
    .MAX_HP      (MaxHp),
    .HOLD_FRAMES (Hold),
    .DRAIN_FRAMES(Drain)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (hif.slave)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: trail value is derived from ticks since the last accepted hit.
  int mHp[2];
  int mHpp0[2];
  int mK[2];
  bit mKo[2];

  bit rsS;
  bit dvS[2];
  int amtS[2];

  logic [HP_W-1:0] obsHp[2];
  logic [HP_W-1:0] obsHpp[2];
  logic            obsKo[2];

  function automatic int exp_hpp(int p);
    int dec;
    int v;
    dec = (mK[p] >= Hold) ? (mK[p] - Hold) / Drain : 0;
    v = mHpp0[p] - dec;
    if (v < mHp[p]) v = mHp[p];
    return v;
  endfunction

  task automatic model_restore();
    for (int p = 0; p < 2; p++) begin
      mHp[p]   = MaxHp;
      mHpp0[p] = MaxHp;
      mK[p]    = 0;
      mKo[p]   = 1'b0;
    end
  endtask

  task automatic model_edge(input bit tk);
    if (Reset || rsS) begin
      model_restore();
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (dvS[p] && !mKo[p]) begin
          mHpp0[p] = exp_hpp(p);
          mHp[p]   = (amtS[p] >= mHp[p]) ? 0 : mHp[p] - amtS[p];
          if (mHp[p] == 0) mKo[p] = 1'b1;
          mK[p] = 0;
        end else if (tk) begin
          mK[p]++;
        end
      end
    end
  endtask

  task automatic drive();
    hif.round_start = rsS;
    hif.dmg_valid1  = dvS[0];
    hif.dmg_valid2  = dvS[1];
    hif.dmg_amt1    = DMG_W'(amtS[0]);
    hif.dmg_amt2    = DMG_W'(amtS[1]);
  endtask

  task automatic sample();
    obsHp[0]  = hif.HP1;
    obsHp[1]  = hif.HP2;
    obsHpp[0] = hif.HPP1;
    obsHpp[1] = hif.HPP2;
    obsKo[0]  = hif.KO1;
    obsKo[1]  = hif.KO2;
  endtask

  // tk tells the model whether the internal tick is consumed at this edge.
  task automatic clk_step(input bit tk);
    drive();
    @(posedge Clk);
    model_edge(tk);
    #1;
    rsS    = 1'b0;
    dvS[0] = 1'b0;
    dvS[1] = 1'b0;
    drive();
    sample();
  endtask

  task automatic hit(input bit d1, input int a1, input bit d2, input int a2);
    dvS[0] = d1; amtS[0] = a1;
    dvS[1] = d2; amtS[1] = a2;
    clk_step(1'b0);
  endtask

  task automatic round_start_pulse();
    rsS = 1'b1;
    clk_step(1'b0);
  endtask

  // Tick is consumed at the third edge after frame_clk rises; damage args land on that edge.
  task automatic frame(input bit d1, input int a1, input bit d2, input int a2);
    hif.frame_clk = 1'b1;
    clk_step(1'b0);
    clk_step(1'b0);
    hif.frame_clk = 1'b0;
    dvS[0] = d1; amtS[0] = a1;
    dvS[1] = d2; amtS[1] = a2;
    clk_step(1'b1);
    clk_step(1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    hif.frame_clk = 1'b0;
    clk_step(1'b0);
    clk_step(1'b0);
    Reset = 1'b0;
    clk_step(1'b0);
    for (int f = 0; f <= 5; f++) begin
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (obsHp[p] !== HP_W'(MaxHp) || obsHpp[p] !== HP_W'(MaxHp) || obsKo[p] !== 1'b0) begin
          errors++;
          $display("FAIL reset p%0d frame%0d: got hp=%0d hpp=%0d ko=%b want hp=100 hpp=100 ko=0",
                   p + 1, f, obsHp[p], obsHpp[p], obsKo[p]);
        end
      end
      if (f < 5) frames(1);
    end
  endtask

  task automatic test_single_hit();
    hit(1'b1, 10, 1'b0, 0);
    checks++;
    if (obsHp[0] !== 10'd90 || obsHpp[0] !== 10'd100) begin
      errors++;
      $display("FAIL single_hit latency: got hp1=%0d hpp1=%0d want 90/100", obsHp[0], obsHpp[0]);
    end
    for (int f = 1; f <= 50; f++) begin
      frames(1);
      checks++;
      if (obsHpp[0] !== HP_W'(exp_hpp(0)) || obsHp[0] !== HP_W'(mHp[0])) begin
        errors++;
        $display("FAIL single_hit tick%0d: got hp1=%0d hpp1=%0d want %0d/%0d",
                 f, obsHp[0], obsHpp[0], mHp[0], exp_hpp(0));
      end
      if (f == 30 || f == 32 || f == 50) begin
        checks++;
        if (obsHpp[0] !== ((f == 30) ? 10'd100 : (f == 32) ? 10'd99 : 10'd90)) begin
          errors++;
          $display("FAIL single_hit milestone tick%0d: got hpp1=%0d", f, obsHpp[0]);
        end
      end
    end
    checks++;
    if (obsHp[1] !== 10'd100 || obsHpp[1] !== 10'd100 || obsKo[1] !== 1'b0) begin
      errors++;
      $display("FAIL single_hit p2 untouched: got hp2=%0d hpp2=%0d ko2=%b want 100/100/0",
               obsHp[1], obsHpp[1], obsKo[1]);
    end
  endtask

  task automatic test_ko();
    hit(1'b0, 0, 1'b1, 150);
    checks++;
    if (obsHp[1] !== 10'd0 || obsKo[1] !== 1'b1) begin
      errors++;
      $display("FAIL ko set: got hp2=%0d ko2=%b want 0/1", obsHp[1], obsKo[1]);
    end
    hit(1'b0, 0, 1'b1, 5);
    checks++;
    if (obsHp[1] !== 10'd0 || obsKo[1] !== 1'b1 || obsHpp[1] !== 10'd100) begin
      errors++;
      $display("FAIL ko ignore: got hp2=%0d ko2=%b hpp2=%0d want 0/1/100",
               obsHp[1], obsKo[1], obsHpp[1]);
    end
    frames(229);
    checks++;
    if (obsHpp[1] !== 10'd1) begin
      errors++;
      $display("FAIL ko drain tick229: got hpp2=%0d want 1", obsHpp[1]);
    end
    frames(1);
    checks++;
    if (obsHpp[1] !== 10'd0 || obsKo[1] !== 1'b1) begin
      errors++;
      $display("FAIL ko drain tick230: got hpp2=%0d ko2=%b want 0/1", obsHpp[1], obsKo[1]);
    end
  endtask

  task automatic test_rehit();
    round_start_pulse();
    hit(1'b1, 10, 1'b0, 0);
    frames(40);
    checks++;
    if (obsHp[0] !== 10'd90 || obsHpp[0] !== 10'd95) begin
      errors++;
      $display("FAIL rehit setup: got hp1=%0d hpp1=%0d want 90/95", obsHp[0], obsHpp[0]);
    end
    hit(1'b1, 5, 1'b0, 0);
    checks++;
    if (obsHp[0] !== 10'd85 || obsHpp[0] !== 10'd95) begin
      errors++;
      $display("FAIL rehit hit: got hp1=%0d hpp1=%0d want 85/95", obsHp[0], obsHpp[0]);
    end
    for (int f = 1; f <= 30; f++) begin
      frames(1);
      checks++;
      if (obsHpp[0] !== 10'd95) begin
        errors++;
        $display("FAIL rehit hold tick%0d: got hpp1=%0d want 95", f, obsHpp[0]);
      end
    end
    frames(20);
    checks++;
    if (obsHpp[0] !== 10'd85 || obsHpp[0] !== HP_W'(exp_hpp(0))) begin
      errors++;
      $display("FAIL rehit drain: got hpp1=%0d want 85", obsHpp[0]);
    end
  endtask

  task automatic test_round_start_priority();
    hit(1'b0, 0, 1'b1, 200);
    checks++;
    if (obsKo[1] !== 1'b1) begin
      errors++;
      $display("FAIL rs_prio setup: got ko2=%b want 1", obsKo[1]);
    end
    rsS    = 1'b1;
    dvS[0] = 1'b1;
    amtS[0] = 20;
    clk_step(1'b0);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (obsHp[p] !== 10'd100 || obsHpp[p] !== 10'd100 || obsKo[p] !== 1'b0) begin
        errors++;
        $display("FAIL rs_prio p%0d: got hp=%0d hpp=%0d ko=%b want 100/100/0",
                 p + 1, obsHp[p], obsHpp[p], obsKo[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    round_start_pulse();
    hit(1'b1, 10, 1'b0, 0);
    frames(33);
    checks++;
    if (obsHpp[0] !== 10'd99) begin
      errors++;
      $display("FAIL b2b setup: got hpp1=%0d want 99", obsHpp[0]);
    end
    frame(1'b1, 7, 1'b1, 3);
    checks++;
    if (obsHp[0] !== 10'd83 || obsHp[1] !== 10'd97 || obsHpp[0] !== 10'd99 ||
        obsHpp[1] !== 10'd100) begin
      errors++;
      $display("FAIL b2b coincide: got hp1=%0d hp2=%0d hpp1=%0d hpp2=%0d want 83/97/99/100",
               obsHp[0], obsHp[1], obsHpp[0], obsHpp[1]);
    end
    frames(30);
    checks++;
    if (obsHpp[0] !== 10'd99 || obsHpp[1] !== 10'd100) begin
      errors++;
      $display("FAIL b2b hold: got hpp1=%0d hpp2=%0d want 99/100", obsHpp[0], obsHpp[1]);
    end
    frames(2);
    checks++;
    if (obsHpp[0] !== 10'd98 || obsHpp[1] !== 10'd99) begin
      errors++;
      $display("FAIL b2b drain: got hpp1=%0d hpp2=%0d want 98/99", obsHpp[0], obsHpp[1]);
    end
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        round_start_pulse();
      end else if (op <= 4) begin
        hit(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 40)));
      end else if (op <= 8) begin
        frames(int'($urandom_range(1, 6)));
      end else begin
        frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (obsHp[p] !== HP_W'(mHp[p]) || obsHpp[p] !== HP_W'(exp_hpp(p)) ||
            obsKo[p] !== mKo[p]) begin
          errors++;
          $display("FAIL random op%0d p%0d: got hp=%0d hpp=%0d ko=%b want hp=%0d hpp=%0d ko=%b",
                   i, p + 1, obsHp[p], obsHpp[p], obsKo[p], mHp[p], exp_hpp(p), mKo[p]);
        end
      end
    end
  endtask

  initial begin
    rsS     = 1'b0;
    dvS[0]  = 1'b0;
    dvS[1]  = 1'b0;
    amtS[0] = 0;
    amtS[1] = 0;
    hif.frame_clk = 1'b0;
    drive();
    model_restore();
    test_reset();
    test_single_hit();
    test_ko();
    test_rehit();
    test_round_start_priority();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
